mbm_log_multiplier: RTL and testbench

- Approximate unsigned integer multiplier using the Minimally Biased Multiplier (MBM) scheme.
- Mitchell logarithmic multiplication plus a constant error-correction term that removes most of Mitchell's negative bias.
- Used as the approximate significand multiplier inside the floating-point MAC datapath.
- One registered output stage; otherwise combinational.

---
 rtl/mbm_pkg.sv | 22 ++
 rtl/mbm_lod.sv | 27 ++
 rtl/mbm_log_multiplier.sv | 92 +++++++++
 tb/tb_mbm_log_multiplier.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mbm_pkg.sv
// Shared constants and helpers for the MBM approximate logarithmic multiplier.
// Default geometry matches the 8-bit significand multiplier in the FP MAC.
package mbm_pkg;

    localparam int MBM_DEF_W   = 8;
    localparam int MBM_DEF_F   = MBM_DEF_W - 1;
    localparam int unsigned MBM_DEF_SAT = (32'd1 << (2 * MBM_DEF_W)) - 32'd1;

    function automatic int frac_width(input int w);
        return w - 1;
    endfunction

    // round(2^f / 12): the constant that cancels most of Mitchell's negative bias
    function automatic int corr_const(input int f);
        return ((1 << f) + 6) / 12;
    endfunction

    function automatic int k_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mbm_lod.sv
// Leading-one detector: characteristic k, zero flag and the bits below the
// leading one left-justified into an F-bit fraction.
module mbm_lod
    import mbm_pkg::*;
#(
    parameter int W = MBM_DEF_W
) (
    input  logic [W-1:0]             operand,
    output logic [k_width(W)-1:0]    k,
    output logic                     zero,
    output logic [frac_width(W)-1:0] frac
);

    localparam int F  = frac_width(W);
    localparam int KW = k_width(W);

    always_comb begin
        k = '0;
        for (int i = 0; i < W; i++) begin
            if (operand[i]) k = KW'(i);
        end
        zero = (operand == '0);
        // Shifting the leading one up to bit W-1 leaves the fraction in the low F bits
        frac = F'(operand << (KW'(F) - k));
    end

endmodule

// File: rtl/mbm_log_multiplier.sv
// Minimally Biased Multiplier: Mitchell log multiply plus a constant correction,
// one registered output stage.
module mbm_log_multiplier
    import mbm_pkg::*;
#(
    parameter int BIT_WIDTH  = MBM_DEF_W,
    parameter int TRUNC_BITS = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [BIT_WIDTH-1:0]   operand_a,
    input  logic [BIT_WIDTH-1:0]   operand_b,
    output logic                   out_valid,
    output logic [2*BIT_WIDTH-1:0] product
);

    localparam int W   = BIT_WIDTH;
    localparam int F   = frac_width(W);
    localparam int KW  = k_width(W);
    localparam int SHW = F + 2 + 2 * W - 1;

    localparam logic [F+1:0] ONE_V    = (F+2)'(1 << F);
    localparam logic [F+1:0] C_V      = (F+2)'(corr_const(F));
    localparam logic [F+1:0] C_HALF_V = (F+2)'(corr_const(F) / 2);
    localparam logic [F-1:0] TMASK    = ~F'((1 << TRUNC_BITS) - 1);
    localparam logic [2*W-1:0] SAT_V  = '1;

    logic [KW-1:0]  ka, kb;
    logic           za, zb;
    logic [F-1:0]   xa_raw, xb_raw, xa, xb;
    logic [F:0]     s;
    logic           carry1;
    logic [F+1:0]   m;
    logic [KW:0]    e;
    logic [SHW-1:0] wide;
    logic [2*W:0]   f_full;
    logic [2*W-1:0] result;

    logic [2*W-1:0] product_d, product_q;
    logic           out_valid_d, out_valid_q;

    mbm_lod #(.W(W)) u_lod_a (
        .operand (operand_a),
        .k       (ka),
        .zero    (za),
        .frac    (xa_raw)
    );

    mbm_lod #(.W(W)) u_lod_b (
        .operand (operand_b),
        .k       (kb),
        .zero    (zb),
        .frac    (xb_raw)
    );

    always_comb begin
        xa     = xa_raw & TMASK;
        xb     = xb_raw & TMASK;
        s      = {1'b0, xa} + {1'b0, xb};
        carry1 = s[F];
        // M is F+2 bits wide so the corrected sum's own overflow (carry2) survives
        if (carry1) m = {1'b0, s} + C_HALF_V;
        else        m = ONE_V + {1'b0, s} + C_V;
        e      = {1'b0, ka} + {1'b0, kb} + {{KW{1'b0}}, carry1};
        wide   = SHW'(m) << e;
        f_full = (2*W+1)'(wide >> F);
        if (za || zb)        result = '0;
        else if (f_full[2*W]) result = SAT_V;
        else                 result = f_full[2*W-1:0];
    end

    always_comb begin
        out_valid_d = in_valid;
        product_d   = product_q;
        if (in_valid) product_d = result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign product   = product_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mbm_log_multiplier.sv
// Randomized and directed check of mbm_log_multiplier against a behavioural model.
module tb_mbm_log_multiplier;

    localparam int W    = 8;
    localparam int F    = W - 1;
    localparam int TRB  = 0;
    localparam longint SAT = (64'd1 << (2 * W)) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [W-1:0]     operand_a, operand_b;
    logic             out_valid;
    logic [2*W-1:0]   product;

    int n_vec = 0;
    int n_err = 0;

    mbm_log_multiplier #(.BIT_WIDTH(W), .TRUNC_BITS(TRB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // f from the arithmetic definition: log-domain sum, bias constant, floor, saturate
    function automatic longint ref_f(input int a, input int b);
        int ka, kb;
        longint xa, xb, s, m, e, c, f;
        if (a == 0 || b == 0) return 0;
        ka = 0; while ((a >> (ka + 1)) != 0) ka++;
        kb = 0; while ((b >> (kb + 1)) != 0) kb++;
        xa = longint'(a - (1 << ka)) << (F - ka);
        xb = longint'(b - (1 << kb)) << (F - kb);
        xa = (xa >> TRB) << TRB;
        xb = (xb >> TRB) << TRB;
        c  = longint'($rtoi((2.0 ** F) / 12.0 + 0.5));
        s  = xa + xb;
        if (s >= (64'd1 << F)) begin
            m = s + c / 2;
            e = ka + kb + 1;
        end else begin
            m = (64'd1 << F) + s + c;
            e = ka + kb;
        end
        f = (m << e) >> F;
        return (f > SAT) ? SAT : f;
    endfunction

    task automatic step(input int a, input int b, input logic v);
        operand_a = W'(a);
        operand_b = W'(b);
        in_valid  = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    int da[9]  = '{1, 2, 3, 10,  0, 77, 0, 128,   255};
    int db[9]  = '{1, 3, 3, 12, 200, 0, 0, 128,   255};
    int dexp[9] = '{1, 6, 8, 117, 0, 0, 0, 17792, 65535};

    initial begin
        int off, a, b, idx, nz;
        longint exp_prev;
        real rel_sum;

        rst = 1'b1; in_valid = 1'b1; operand_a = 8'd255; operand_b = 8'd255;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("rst_product", product, 0);
            chk("rst_valid", out_valid, 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step(da[i], db[i], 1'b1);
            chk($sformatf("dir_%0dx%0d", da[i], db[i]), product, dexp[i]);
            chk("dir_valid", out_valid, 1);
        end

        // back-to-back then idle hold
        step(1, 1, 1'b1); chk("b2b_0", product, 1); chk("b2b_v0", out_valid, 1);
        step(2, 3, 1'b1); chk("b2b_1", product, 6); chk("b2b_v1", out_valid, 1);
        step(3, 3, 1'b1); chk("b2b_2", product, 8); chk("b2b_v2", out_valid, 1);
        step(5, 9, 1'b0); chk("hold_prod", product, 8); chk("hold_valid", out_valid, 0);
        step(7, 7, 1'b0); chk("hold_prod2", product, 8);

        // full sweep in a randomized bijective order, pipelined one pair per cycle
        off = int'($urandom_range(0, 65535));
        rel_sum = 0.0; nz = 0; exp_prev = 0;
        for (int i = 0; i <= 65536; i++) begin
            if (i < 65536) begin
                idx = ((i * 40503) + off) & 16'hFFFF;
                operand_a = W'(idx >> 8);
                operand_b = W'(idx & 8'hFF);
                in_valid  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            a = int'(operand_a);
            b = int'(operand_b);
            @(posedge clk); @(negedge clk);
            if (i < 65536) begin
                exp_prev = ref_f(a, b);
                chk($sformatf("sweep_%0dx%0d", a, b), product, exp_prev);
                if (a != 0 && b != 0) begin
                    rel_sum += (real'(product) - real'(a * b)) / real'(a * b);
                    nz++;
                end
            end else begin
                chk("sweep_tail_hold", product, exp_prev);
                chk("sweep_tail_valid", out_valid, 0);
            end
        end
        chk("mean_rel_err_within_1pct",
            ((rel_sum / real'(nz)) <= 0.01 && (rel_sum / real'(nz)) >= -0.01) ? 1 : 0, 1);

        // reset mid-stream overrides a valid input
        rst = 1'b1;
        step(200, 200, 1'b1);
        chk("rst2_product", product, 0);
        chk("rst2_valid", out_valid, 0);
        rst = 1'b0;
        step(200, 200, 1'b1);
        chk("post_rst2", product, ref_f(200, 200));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
